pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Supervises the video PLL (27 MHz crystal in, 5x pixel clock out) from the crystal clock domain.
- Drives the PLL RESET input and synchronizes the asynchronous lock output.
- Holds downstream pixel/TMDS logic in reset until lock has been stable.
- Retries lock acquisition on timeout, recovers automatically from lock loss, and accepts a software restart, e.g. after a PLL reconfiguration or video-mode change.

Parameters:
- RESET_CYCLES, 16: cycles pll_reset is held high per attempt; must be 1 or more.
- LOCK_TIMEOUT, 27000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 27 MHz).
- LOCK_FILTER, 4: consecutive synchronized-lock cycles needed to count as locked, or as unlocked while in RUN.
- STABLE_CYCLES, 1024: cycles lock must stay continuously high before downstream reset is released.
- MAX_RETRIES, 3: failed attempts allowed before entering FAULT.

Ports:
- clk  in  1  crystal clock (27 MHz), the only clock.
- resetn  in  1  synchronous, active-low reset.
- lock  in  1  PLL lock, asynchronous to clk.
- restart  in  1  single-cycle request to re-run the full sequence.
- pll_reset  out  1  to PLL RESET, active high.
- domain_rst_n  out  1  active-low reset for the pixel-clock domain; the consumer synchronizes its deassertion.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  2  failed attempts since the last success, restart or reset.
- loss_count  out  8  lock-loss events seen in RUN; saturates at 255.

Behaviour:
- Every flop resets synchronously while resetn=0.
- Reset values: state=PRESET, pll_reset=1, domain_rst_n=0, ready=0, fault=0, retry_count=0, loss_count=0, all counters 0.
- All outputs are registered.
- lock passes through a 2-flop synchronizer; the result is lock_s. lock_s lags lock by 2 cycles.
- Filter counter: counts consecutive cycles of the awaited lock_s level and clears when the level differs.
- States:
  - PRESET: pll_reset=1, domain_rst_n=0. Leaves on the cycle where its counter reaches RESET_CYCLES-1, going to WAIT_LOCK with counters cleared. pll_reset is therefore high for exactly RESET_CYCLES cycles.
  - WAIT_LOCK: pll_reset=0. If lock_s=1 for LOCK_FILTER consecutive cycles, go to STABLE. Otherwise, when the timeout counter reaches LOCK_TIMEOUT-1, the attempt fails.
    - On failure with retry_count+1 < MAX_RETRIES: increment retry_count and go to PRESET.
    - On failure otherwise: go to FAULT (retry_count ends at MAX_RETRIES, saturated to the 2-bit width).
  - STABLE: if lock_s=1 continuously for STABLE_CYCLES, go to RUN, clear retry_count, and drive domain_rst_n=1 and ready=1 in the same registered cycle. Any lock_s=0 cycle returns to WAIT_LOCK with the timeout counter restarted; retry_count is not incremented.
  - RUN: if lock_s=0 for LOCK_FILTER consecutive cycles:
    - next cycle: domain_rst_n=0 and ready=0;
    - loss_count increments (saturating);
    - state goes to PRESET.
    - Glitches shorter than LOCK_FILTER are ignored.
  - FAULT: pll_reset=1, domain_rst_n=0, fault=1. Left only by restart or resetn.
- restart=1 in any state:
  - next state is PRESET, retry_count cleared, counters cleared, fault cleared, domain_rst_n=0 and ready=0 on the next cycle;
  - loss_count is kept;
  - restart overrides every same-cycle transition, including a timeout or an entry into RUN.
- resetn=0 mid-sequence overrides everything, including restart.
- domain_rst_n=1 if and only if state=RUN.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_FILTER=2, STABLE_CYCLES=8, MAX_RETRIES=3):
1. Normal bring-up: release resetn, raise lock 3 cycles after pll_reset falls and hold it -> pll_reset high exactly 4 cycles; domain_rst_n and ready rise 2 (sync) + 2 (filter) + 8 (stable) cycles after lock rises, ±1 from the state-registration cycle, pinned exactly in the bench; retry_count=0.
2. Never lock -> three PRESET/WAIT_LOCK cycles of 4+20 clocks each; retry_count reads 1, then 2; then fault=1, pll_reset=1, domain_rst_n=0, and they stay there.
3. Glitch while in RUN: drop lock for 1 cycle -> no change. Drop it for 3 cycles -> domain_rst_n=0 after sync+filter latency, loss_count=1, full re-sequence, RUN reached again.
4. Lock drops in STABLE after 5 cycles -> back to WAIT_LOCK, retry_count unchanged, domain_rst_n stays 0 throughout.
5. restart pulsed while in FAULT, and again in the same cycle that STABLE would enter RUN -> PRESET taken both times, fault cleared, retry_count=0, loss_count preserved.
6. Saturation and reset priority: force 256 lock losses -> loss_count=255. resetn=0 together with restart=1 -> all reset values.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and the surrounding clock/reset logic.
// The slave side is the sequencer; the master side provides lock/restart.
interface pll_lock_sequencer_if;
    logic       lock;
    logic       restart;
    logic       pll_reset;
    logic       domain_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    modport master (
        output lock, restart,
        input  pll_reset, domain_rst_n, ready, fault, retry_count, loss_count
    );

    modport slave (
        input  lock, restart,
        output pll_reset, domain_rst_n, ready, fault, retry_count, loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Video PLL supervisor in the crystal domain: drives PLL reset, filters the asynchronous
// lock, holds the pixel domain in reset until lock is stable, retries and recovers on loss.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int LOCK_FILTER   = 4,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    pll_lock_sequencer_if.slave  bus
);
    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int FW        = $clog2(LOCK_FILTER + 1);

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [31:0]   RETRY_LIMIT  = 32'(MAX_RETRIES);
    localparam logic [1:0]    RETRY_FINAL  = (MAX_RETRIES > 3) ? 2'd3 : 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PRESET    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [FW-1:0] filt_r, filt_s;
    logic [1:0]    retry_r, retry_s;
    logic [7:0]    loss_r, loss_s;
    logic          lock_meta_r, lock_sync_r;
    logic          pll_reset_r, pll_reset_s;
    logic          domain_rst_n_r, domain_rst_n_s;
    logic          ready_r, ready_s;
    logic          fault_r, fault_s;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= bus.lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r        <= ST_PRESET;
            cnt_r          <= '0;
            filt_r         <= '0;
            retry_r        <= 2'd0;
            loss_r         <= 8'd0;
            pll_reset_r    <= 1'b1;
            domain_rst_n_r <= 1'b0;
            ready_r        <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            filt_r         <= filt_s;
            retry_r        <= retry_s;
            loss_r         <= loss_s;
            pll_reset_r    <= pll_reset_s;
            domain_rst_n_r <= domain_rst_n_s;
            ready_r        <= ready_s;
            fault_r        <= fault_s;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        filt_s  = filt_r;
        retry_s = retry_r;
        loss_s  = loss_r;

        if (bus.restart) begin
            state_s = ST_PRESET;
            cnt_s   = '0;
            filt_s  = '0;
            retry_s = 2'd0;
        end else begin
            case (state_r)
                ST_PRESET: begin
                    if (cnt_r == RESET_LAST) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = '0;
                        filt_s  = '0;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    cnt_s  = cnt_r + CW'(1);
                    filt_s = lock_sync_r ? (filt_r + FW'(1)) : '0;
                    if (lock_sync_r && (filt_r == FILTER_LAST)) begin
                        state_s = ST_STABLE;
                        cnt_s   = '0;
                        filt_s  = '0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_s  = '0;
                        filt_s = '0;
                        if (({30'd0, retry_r} + 32'd1) < RETRY_LIMIT) begin
                            retry_s = retry_r + 2'd1;
                            state_s = ST_PRESET;
                        end else begin
                            retry_s = RETRY_FINAL;
                            state_s = ST_FAULT;
                        end
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_sync_r) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = '0;
                        filt_s  = '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s = ST_RUN;
                        cnt_s   = '0;
                        filt_s  = '0;
                        retry_s = 2'd0;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    filt_s = lock_sync_r ? '0 : (filt_r + FW'(1));
                    if (!lock_sync_r && (filt_r == FILTER_LAST)) begin
                        state_s = ST_PRESET;
                        cnt_s   = '0;
                        filt_s  = '0;
                        loss_s  = (loss_r == 8'hFF) ? loss_r : (loss_r + 8'd1);
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_s = ST_FAULT;
                end
                default: begin
                    state_s = ST_PRESET;
                    cnt_s   = '0;
                    filt_s  = '0;
                end
            endcase
        end

        pll_reset_s    = (state_s == ST_PRESET) || (state_s == ST_FAULT);
        domain_rst_n_s = (state_s == ST_RUN);
        ready_s        = (state_s == ST_RUN);
        fault_s        = (state_s == ST_FAULT);
    end

    assign bus.pll_reset    = pll_reset_r;
    assign bus.domain_rst_n = domain_rst_n_r;
    assign bus.ready        = ready_r;
    assign bus.fault        = fault_r;
    assign bus.retry_count  = retry_r;
    assign bus.loss_count   = loss_r;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed vector table, saturation/reset sequences and
// randomized lock/restart/reset traffic, all compared against a history-based reference.
module tb_pll_lock_sequencer;
    localparam int R = 4, T = 20, F = 2, S = 8, MAXR = 3;
    localparam int P_PRESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;

    logic clk = 1'b0;
    logic resetn;
    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RESET_CYCLES(R), .LOCK_TIMEOUT(T), .LOCK_FILTER(F),
        .STABLE_CYCLES(S), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // {pll_reset, domain_rst_n, ready, fault, retry_count, loss_count}
    logic [13:0] act;
    assign act = {bus.pll_reset, bus.domain_rst_n, bus.ready, bus.fault, bus.retry_count, bus.loss_count};

    typedef struct {
        bit          rn;
        bit          lk;
        bit          rs;
        int          n;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference: phase plus the edge at which it began; decisions look back over sampled lock history.
    int m_phase = P_PRESET, m_entry = 1, m_retry = 0, m_loss = 0, m_edge = 0;
    bit m_d1 = 1'b0, m_d2 = 1'b0;
    bit m_hist[256];

    function automatic logic [13:0] mk(input bit p, input bit d, input bit r, input bit f,
                                       input int rt, input int ls);
        return {p, d, r, f, rt[1:0], ls[7:0]};
    endfunction

    function automatic vec_t v(input bit rn, input bit lk, input bit rs, input int n, input logic [13:0] e);
        vec_t x;
        x.rn = rn; x.lk = lk; x.rs = rs; x.n = n; x.exp = e;
        return x;
    endfunction

    function automatic logic [13:0] model_out();
        return mk((m_phase == P_PRESET) || (m_phase == P_FAULT), m_phase == P_RUN,
                  m_phase == P_RUN, m_phase == P_FAULT, m_retry, m_loss);
    endfunction

    function automatic bit held(input bit lvl);
        for (int k = 0; k < F; k++)
            if (m_hist[(m_edge - k) & 255] != lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic go(input int p);
        m_phase = p;
        m_entry = m_edge + 1;
    endtask

    task automatic model_step(input bit rn, input bit lk, input bit rs);
        bit s;
        int age;
        m_edge++;
        if (!rn) begin
            m_d1 = 1'b0; m_d2 = 1'b0; m_retry = 0; m_loss = 0;
            go(P_PRESET);
            return;
        end
        s = m_d2;
        m_d2 = m_d1;
        m_d1 = lk;
        m_hist[m_edge & 255] = s;
        if (rs) begin
            m_retry = 0;
            go(P_PRESET);
            return;
        end
        age = m_edge - m_entry + 1;
        case (m_phase)
            P_PRESET: if (age == R) go(P_WAIT);
            P_WAIT: begin
                if (age >= F && held(1'b1)) go(P_STABLE);
                else if (age == T) begin
                    if (m_retry + 1 < MAXR) begin
                        m_retry++;
                        go(P_PRESET);
                    end else begin
                        m_retry = (MAXR > 3) ? 3 : MAXR;
                        go(P_FAULT);
                    end
                end
            end
            P_STABLE: begin
                if (!s) go(P_WAIT);
                else if (age == S) begin
                    m_retry = 0;
                    go(P_RUN);
                end
            end
            P_RUN: begin
                if (age >= F && held(1'b0)) begin
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    go(P_PRESET);
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Drives one clock of stimulus (called at a falling edge), compares against the model after it.
    task automatic apply(input bit rn, input bit lk, input bit rs);
        resetn      = rn;
        bus.lock    = lk;
        bus.restart = rs;
        @(posedge clk);
        model_step(rn, lk, rs);
        @(negedge clk);
        check("model", act, model_out());
    endtask

    initial begin
        bit cur;
        int mode;
        bit rn_r, rs_r;

        resetn = 1'b0;
        bus.lock = 1'b0;
        bus.restart = 1'b0;

        // bring-up
        vecs.push_back(v(0, 0, 0,  3, mk(1, 0, 0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 0,  3, mk(1, 0, 0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 0,  1, mk(0, 0, 0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 0,  3, mk(0, 0, 0, 0, 0, 0)));
        vecs.push_back(v(1, 1, 0, 11, mk(0, 0, 0, 0, 0, 0)));
        vecs.push_back(v(1, 1, 0,  1, mk(0, 1, 1, 0, 0, 0)));
        vecs.push_back(v(1, 1, 0,  5, mk(0, 1, 1, 0, 0, 0)));
        // glitch in RUN, then a real loss and re-sequence
        vecs.push_back(v(1, 0, 0,  1, mk(0, 1, 1, 0, 0, 0)));
        vecs.push_back(v(1, 1, 0,  4, mk(0, 1, 1, 0, 0, 0)));
        vecs.push_back(v(1, 0, 0,  3, mk(0, 1, 1, 0, 0, 0)));
        vecs.push_back(v(1, 1, 0,  1, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0, 13, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0,  1, mk(0, 1, 1, 0, 0, 1)));
        // lock drop after 5 STABLE cycles
        vecs.push_back(v(1, 1, 1,  1, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0,  9, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 0, 0,  1, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0, 11, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0,  1, mk(0, 1, 1, 0, 0, 1)));
        // never lock: two retries then FAULT
        vecs.push_back(v(1, 0, 1,  1, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 0, 0,  3, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 0, 0,  1, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 0, 0, 19, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 0, 0,  1, mk(1, 0, 0, 0, 1, 1)));
        vecs.push_back(v(1, 0, 0, 24, mk(1, 0, 0, 0, 2, 1)));
        vecs.push_back(v(1, 0, 0, 23, mk(0, 0, 0, 0, 2, 1)));
        vecs.push_back(v(1, 0, 0,  1, mk(1, 0, 0, 1, 3, 1)));
        vecs.push_back(v(1, 0, 0, 10, mk(1, 0, 0, 1, 3, 1)));
        // restart out of FAULT, then restart on the cycle RUN would be entered
        vecs.push_back(v(1, 1, 1,  1, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0, 13, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 1,  1, mk(1, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0, 13, mk(0, 0, 0, 0, 0, 1)));
        vecs.push_back(v(1, 1, 0,  1, mk(0, 1, 1, 0, 0, 1)));

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) apply(vecs[i].rn, vecs[i].lk, vecs[i].rs);
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // 256 more lock losses from RUN: counter must stick at 255
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < 3; c++)  apply(1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) apply(1'b1, 1'b1, 1'b0);
        end
        check("loss_sat", act, mk(0, 1, 1, 0, 0, 255));

        apply(1'b0, 1'b1, 1'b1);
        check("reset_over_restart", act, mk(1, 0, 0, 0, 0, 0));

        // randomized traffic in blocks of differing lock behaviour
        cur = 1'b1;
        for (int blk = 0; blk < 20; blk++) begin
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 200; c++) begin
                case (mode)
                    0:       if ($urandom_range(0, 99) < 3)  cur = ~cur;
                    1:       if ($urandom_range(0, 99) < 25) cur = ~cur;
                    default: cur = 1'b0;
                endcase
                rs_r = ($urandom_range(0, 199) == 0);
                rn_r = ($urandom_range(0, 399) != 0);
                apply(rn_r, cur, rs_r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
